// File: rtl/pipe_stage_skid_reg_if.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_stage_skid_reg_if
//  Purpose  : Handshake bundle between an upstream stage, the skid pipeline
//             register and a downstream stage.
//  Signals  : InValid/InReady/InCtrl/InData   - upstream -> register channel
//             OutValid/OutReady/OutCtrl/OutData - register -> downstream channel
//  Modports : slave  - the pipeline register itself
//             master - the surrounding stages (or a testbench)
//  Revision : 1.0 - initial release
// ============================================================================
interface pipe_stage_skid_reg_if #(
  parameter int CTRL_W = 16,
  parameter int DATA_W = 128
);
  logic              InValid;
  logic              InReady;
  logic [CTRL_W-1:0] InCtrl;
  logic [DATA_W-1:0] InData;
  logic              OutValid;
  logic              OutReady;
  logic [CTRL_W-1:0] OutCtrl;
  logic [DATA_W-1:0] OutData;

  modport slave (
    input  InValid, InCtrl, InData, OutReady,
    output InReady, OutValid, OutCtrl, OutData
  );

  modport master (
    output InValid, InCtrl, InData, OutReady,
    input  InReady, OutValid, OutCtrl, OutData
  );
endinterface
`default_nettype wire

// File: rtl/pipe_stage_skid_reg.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_stage_skid_reg
//  Purpose  : Inter-stage pipeline register with valid/ready handshake and a
//             2-entry skid buffer. Carries one control and one data bundle per
//             instruction, supports stall, flush and bubble (zero-control)
//             insertion, and counts bubble cycles for performance debug.
//  Ports    : Clk       - clock, all state updates on posedge
//             Rst_n     - synchronous active-low reset
//             Flush     - discard held and incoming instructions
//             BubbleCnt - saturating count of cycles with OutValid=0
//             bus       - handshake bundle (slave view)
//  Revision : 1.0 - initial release
// ============================================================================
module pipe_stage_skid_reg #(
  parameter int CTRL_W              = 16,
  parameter int DATA_W              = 128,
  parameter bit ZERO_DATA_ON_BUBBLE = 1'b1,
  parameter int CNT_W               = 16
) (
  input  wire logic               Clk,
  input  wire logic               Rst_n,
  input  wire logic               Flush,
  output logic [CNT_W-1:0]        BubbleCnt,
  pipe_stage_skid_reg_if.slave    bus
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_t;

  state_t            state_q;
  logic [CTRL_W-1:0] main_ctrl_q;
  logic [DATA_W-1:0] main_data_q;
  logic [CTRL_W-1:0] skid_ctrl_q;
  logic [DATA_W-1:0] skid_data_q;
  logic [CNT_W-1:0]  bubble_q;
  logic [CNT_W-1:0]  bubble_d;

  logic in_ready;
  logic out_valid;
  logic accept;
  logic take;

  // Ready depends only on registered state, so OutReady never ripples
  // combinationally back to the upstream stage.
  assign in_ready  = (state_q != ST_SKID);
  assign out_valid = (state_q != ST_EMPTY);
  assign accept    = bus.InValid & in_ready;
  assign take      = out_valid & bus.OutReady;

  assign bus.InReady  = in_ready;
  assign bus.OutValid = out_valid;
  // The main entry may keep stale control after it drains, so gate it.
  assign bus.OutCtrl  = out_valid ? main_ctrl_q : '0;

  generate
    if (ZERO_DATA_ON_BUBBLE) begin : g_zero_data
      assign bus.OutData = out_valid ? main_data_q : '0;
    end else begin : g_hold_data
      assign bus.OutData = main_data_q;
    end
  endgenerate

  // Handshake FSM with the main/skid entries. A take in a flush cycle needs no
  // action: the instruction left this cycle and the state empties regardless.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q     <= ST_EMPTY;
      main_ctrl_q <= '0;
      main_data_q <= '0;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
    end else if (Flush) begin
      state_q     <= ST_EMPTY;
      main_ctrl_q <= '0;
      skid_ctrl_q <= '0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_q     <= ST_FULL;
            main_ctrl_q <= bus.InCtrl;
            main_data_q <= bus.InData;
          end
        end
        ST_FULL: begin
          if (accept && take) begin
            main_ctrl_q <= bus.InCtrl;
            main_data_q <= bus.InData;
          end else if (accept) begin
            // Downstream stalled while upstream delivered: park in skid.
            state_q     <= ST_SKID;
            skid_ctrl_q <= bus.InCtrl;
            skid_data_q <= bus.InData;
          end else if (take) begin
            state_q <= ST_EMPTY;
          end
        end
        ST_SKID: begin
          if (take) begin
            state_q     <= ST_FULL;
            main_ctrl_q <= skid_ctrl_q;
            main_data_q <= skid_data_q;
          end
        end
        default: begin
          state_q <= ST_EMPTY;
        end
      endcase
    end
  end

  // Bubble counter: counts edges whose pre-edge OutValid was low; saturates.
  assign bubble_d = (!out_valid && (bubble_q != {CNT_W{1'b1}}))
                    ? bubble_q + CNT_W'(1) : bubble_q;

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      bubble_q <= '0;
    end else begin
      bubble_q <= bubble_d;
    end
  end

  assign BubbleCnt = bubble_q;

endmodule
`default_nettype wire
